// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types and constants for the servo sequencer
package servo_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_HOLD  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_END   = 3'd5
    } state_t;

    // MSB of each 8-bit field inside a ROM word
    localparam int S1_MSB = 31;
    localparam int S2_MSB = 23;
    localparam int S3_MSB = 15;
    localparam int T_MSB  = 7;

    // 20 ms at 50 MHz
    localparam int TICK_DIV_DEF = 1000000;

    // Extract the 8-bit field whose MSB sits at msb
    function automatic logic [7:0] field8(input logic [31:0] word, input int msb);
        return word[msb -: 8];
    endfunction

endpackage

// File: rtl/divisor_20ms.sv
// rtl/divisor_20ms.sv - free-running 20 ms tick divider with synchronous clear
module divisor_20ms
    import servo_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    output logic TICK
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at TICK_DIV-1, forced to zero while cleared
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (CLR || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    // Count register
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick marks the last cycle of each time unit
    assign TICK = (cnt_q == CNT_LAST);

endmodule

// File: rtl/secuenciador_servos.sv
// rtl/secuenciador_servos.sv - walks the servo-position ROM and holds each step's targets
module secuenciador_servos
    import servo_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int LAST_POS = 11,
    parameter int ADDR_W   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              LOOP,
    input  logic [31:0]       DATOS,
    output logic [ADDR_W-1:0] POS,
    output logic [7:0]        SERVO1,
    output logic [7:0]        SERVO2,
    output logic [7:0]        SERVO3,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_POS);

    state_t            state_q;
    logic [ADDR_W-1:0] pos_q;
    logic [7:0]        servo1_q;
    logic [7:0]        servo2_q;
    logic [7:0]        servo3_q;
    logic [7:0]        units_q;
    logic              busy_q;
    logic              done_q;

    logic       tick;
    logic       div_clr;
    logic [7:0] time_field;

    // The divider only runs inside HOLD, so every hold starts from a fresh count
    assign div_clr    = (state_q != ST_HOLD);
    assign time_field = field8(DATOS, T_MSB);

    divisor_20ms #(
        .TICK_DIV (TICK_DIV)
    ) u_divisor (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (div_clr),
        .TICK (tick)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            servo1_q <= '0;
            servo2_q <= '0;
            servo3_q <= '0;
            units_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        pos_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // ROM registers POS on this edge
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    // A zero time field marks the end of the programmed sequence
                    if (time_field == 8'd0) begin
                        state_q <= ST_END;
                    end else begin
                        servo1_q <= field8(DATOS, S1_MSB);
                        servo2_q <= field8(DATOS, S2_MSB);
                        servo3_q <= field8(DATOS, S3_MSB);
                        units_q  <= time_field;
                        state_q  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        units_q <= units_q - 8'd1;
                        if (units_q == 8'd1) begin
                            state_q <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    if (pos_q == LAST_ADDR) begin
                        state_q <= ST_END;
                    end else begin
                        pos_q   <= pos_q + 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_END: begin
                    if (LOOP) begin
                        pos_q   <= '0;
                        state_q <= ST_FETCH;
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign POS    = pos_q;
    assign SERVO1 = servo1_q;
    assign SERVO2 = servo2_q;
    assign SERVO3 = servo3_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_secuenciador_servos.sv
// tb/tb_secuenciador_servos.sv - scoreboard bench for secuenciador_servos
module tb_secuenciador_servos;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        loop_in;
    logic [31:0] datos;
    logic [7:0]  pos;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic [7:0]  s3;
    logic        busy;
    logic        done;

    typedef struct {
        int         cyc;
        logic [7:0] pos;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        logic       busy;
        logic       done;
    } snap_t;

    snap_t exp_q[$];
    snap_t last_e;
    int    cyc       = 0;
    int    n_chk     = 0;
    int    n_pass    = 0;
    bit    term_mode = 1'b0;
    bit    mon_en    = 1'b0;
    int    fe[12];

    secuenciador_servos #(
        .TICK_DIV (4),
        .LAST_POS (11),
        .ADDR_W   (8)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .LOOP   (loop_in),
        .DATOS  (datos),
        .POS    (pos),
        .SERVO1 (s1),
        .SERVO2 (s2),
        .SERVO3 (s3),
        .BUSY   (busy),
        .DONE   (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int a, input bit term);
        logic [31:0] w;
        case (a)
            0:       w = 32'h1020_3005;
            1:       w = 32'h3C40_5003;
            2:       w = 32'h1122_3301;
            3:       w = 32'h4455_6604;
            4:       w = 32'h0102_0302;
            5:       w = 32'h0A0B_0C64;
            6:       w = 32'h2030_4002;
            7:       w = 32'h3040_5002;
            8:       w = 32'h4050_6002;
            9:       w = 32'h5060_7002;
            10:      w = 32'h6070_8002;
            11:      w = 32'h0000_FF02;
            default: w = 32'h0;
        endcase
        if (term && a == 7) w = 32'h0;
        return w;
    endfunction

    // Registered ROM: one cycle of latency from POS to DATOS
    always @(posedge clk) datos <= rom_word(int'(pos), term_mode);

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic bit same(input snap_t a, input snap_t b);
        return (a.pos === b.pos) && (a.s1 === b.s1) && (a.s2 === b.s2) &&
               (a.s3 === b.s3) && (a.busy === b.busy) && (a.done === b.done);
    endfunction

    task automatic exp_push(input int c, input logic [7:0] p, input logic [7:0] a1,
                            input logic [7:0] a2, input logic [7:0] a3,
                            input logic b, input logic d);
        snap_t s;
        s.cyc = c; s.pos = p; s.s1 = a1; s.s2 = a2; s.s3 = a3; s.busy = b; s.done = d;
        if (!same(s, last_e)) exp_q.push_back(s);
        last_e = s;
    endtask

    task automatic exp_idle(input int c);
        exp_push(c, last_e.pos, last_e.s1, last_e.s2, last_e.s3, 1'b0, 1'b0);
    endtask

    // Expected events of one pass starting with FETCH of address 0 at edge f0
    task automatic exp_pass(input int f0, input bit term, input bit loop_end,
                            input int stop_addr, output int f_end);
        int          f;
        int          t;
        bit          fin;
        bit          partial;
        logic [31:0] w;
        f = f0; fin = 1'b0; partial = 1'b0; f_end = f0;
        for (int a = 0; a < 12 && !fin; a++) begin
            w = rom_word(a, term);
            t = int'(w[7:0]);
            fe[a] = f;
            exp_push(f, 8'(a), last_e.s1, last_e.s2, last_e.s3, 1'b1, 1'b0);
            if (t == 0) begin
                f_end = f + 3;
                fin = 1'b1;
            end else begin
                exp_push(f + 2, 8'(a), w[31:24], w[23:16], w[15:8], 1'b1, 1'b0);
                if (a == stop_addr) begin
                    f_end = f + 2;
                    fin = 1'b1;
                    partial = 1'b1;
                end else if (a == 11) begin
                    f_end = f + 4 + 4 * t;
                    fin = 1'b1;
                end else begin
                    f = f + 3 + 4 * t;
                end
            end
        end
        if (!loop_end && !partial)
            exp_push(f_end, last_e.pos, last_e.s1, last_e.s2, last_e.s3, 1'b0, 1'b1);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t0;
        t0 = cyc;
        while (exp_q.size() != 0 && cyc < t0 + budget) @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain_%s: %0d events still pending, required 0", name, exp_q.size());
    endtask

    // Monitor: every change of the visible outputs is one event to match
    initial begin
        snap_t cur;
        snap_t prv;
        snap_t e;
        prv.cyc = 0; prv.pos = 0; prv.s1 = 0; prv.s2 = 0; prv.s3 = 0; prv.busy = 0; prv.done = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur.cyc = cyc; cur.pos = pos; cur.s1 = s1; cur.s2 = s2; cur.s3 = s3;
                cur.busy = busy; cur.done = done;
                if (!same(cur, prv)) begin
                    prv = cur;
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL event_unexpected: got cyc=%0d pos=%h s=%h/%h/%h busy=%b done=%b, required no event",
                                 cur.cyc, cur.pos, cur.s1, cur.s2, cur.s3, cur.busy, cur.done);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc == cur.cyc && same(e, cur)) n_pass++;
                        else $display("FAIL event: got cyc=%0d pos=%h s=%h/%h/%h busy=%b done=%b, required cyc=%0d pos=%h s=%h/%h/%h busy=%b done=%b",
                                      cur.cyc, cur.pos, cur.s1, cur.s2, cur.s3, cur.busy, cur.done,
                                      e.cyc, e.pos, e.s1, e.s2, e.s3, e.busy, e.done);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        int e1;
        int e2;
        int h;
        rst = 1'b1; start = 1'b0; loop_in = 1'b0;
        last_e.cyc = 0; last_e.pos = 0; last_e.s1 = 0; last_e.s2 = 0; last_e.s3 = 0;
        last_e.busy = 0; last_e.done = 0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (pos === 8'h0 && s1 === 8'h0 && s2 === 8'h0 && s3 === 8'h0 && busy === 1'b0 && done === 1'b0)
            n_pass++;
        else
            $display("FAIL reset_state: got pos=%h s=%h/%h/%h busy=%b done=%b, required all zero",
                     pos, s1, s2, s3, busy, done);
        rst = 1'b0;
        mon_en = 1'b1;

        // Nominal pass, START pulsed mid-HOLD, START held through DONE
        c = cyc; start = 1'b1;
        exp_pass(c + 1, 1'b0, 1'b0, -1, e1);
        wait_cyc(c + 1); start = 1'b0;
        wait_cyc(fe[3] + 5); start = 1'b1;
        wait_cyc(fe[3] + 6); start = 1'b0;
        wait_cyc(fe[11] + 5); start = 1'b1; term_mode = 1'b1;
        // Terminator pass re-triggered by the held START
        exp_pass(e1 + 1, 1'b1, 1'b0, -1, e2);
        exp_idle(e2 + 1);
        wait_cyc(e1 + 1); start = 1'b0;
        wait_cyc(e2 + 2);
        wait_drain("nominal_term", 50);

        // Loop: first pass restarts, LOOP cleared during the second
        term_mode = 1'b0; loop_in = 1'b1;
        c = cyc; start = 1'b1;
        exp_pass(c + 1, 1'b0, 1'b1, -1, e1);
        exp_pass(e1, 1'b0, 1'b0, -1, e2);
        exp_idle(e2 + 1);
        wait_cyc(c + 1); start = 1'b0;
        wait_cyc(e1 + 50); loop_in = 1'b0;
        wait_cyc(e2 + 2);
        wait_drain("loop", 50);

        // Reset 200 cycles into the HOLD of address 5
        c = cyc; start = 1'b1;
        exp_pass(c + 1, 1'b0, 1'b0, 5, h);
        exp_push(h + 200, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
        wait_cyc(c + 1); start = 1'b0;
        wait_cyc(h + 199); rst = 1'b1;
        wait_cyc(h + 200); rst = 1'b0;
        wait_drain("reset", 50);

        // Clean restart after reset
        c = cyc; start = 1'b1;
        exp_pass(c + 1, 1'b0, 1'b0, -1, e1);
        exp_idle(e1 + 1);
        wait_cyc(c + 1); start = 1'b0;
        wait_cyc(e1 + 2);
        wait_drain("restart", 50);

        repeat (10) @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL leftover: %0d events pending, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
